// File: rtl/memctrl_pkg.sv
// Shared definitions for the host initiator of the interleaved SRAM memory
// controller. It holds the initiator state encoding, the default bus widths
// and the address field positions, which are also used by the controller's
// address-decode stage.
package memctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    // Address layout: [15:14] bank, [13:10] macro, [9:0] word.
    localparam int BANK_MSB  = 15;
    localparam int BANK_LSB  = 14;
    localparam int MACRO_MSB = 13;
    localparam int MACRO_LSB = 10;
    localparam int WORD_MSB  = 9;
    localparam int WORD_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/memctrl_rd_tracker.sv
// Read latency tracker.
// A valid bit travels down an RD_LAT+1 deep shift register for every read
// beat issued on the memory strobes. When it reaches stage RD_LAT-1, ODATA is
// valid, so it is captured into rdata. The final stage is rvalid itself.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   issue          a read beat is visible on the memory outputs this cycle
//   odata          read byte from the controller
//   rvalid, rdata  returned beat to the host
//   empty          nothing is in flight apart from a beat returned this cycle
module memctrl_rd_tracker #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] odata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              empty
);

    logic [RD_LAT:0]   vld_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg[0] <= 1'b0;
        end else begin
            vld_reg[0] <= issue;
        end
    end

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg[gi] <= 1'b0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

    // ODATA is valid while the beat sits in stage RD_LAT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (vld_reg[RD_LAT-1]) begin
            rdata_reg <= odata;
        end
    end

    assign rvalid = vld_reg[RD_LAT];
    assign rdata  = rdata_reg;
    // The returning stage is excluded, so empty together with rvalid marks
    // the final beat of a burst.
    assign empty  = ~issue & ~(|vld_reg[RD_LAT-1:0]);

endmodule

// File: rtl/memctrl_host_initiator.sv
// Host-side initiator for the interleaved SRAM memory controller.
// Accepts burst requests on a valid/ready interface, expands them into
// registered per-beat controller strobes and returns read data in order.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   REQ_VALID/READY/WRITE/ADDR/LEN   burst request (LEN = beats-1)
//   WDATA/WVALID/WREADY       write beat stream
//   RDATA/RVALID              read return, no backpressure
//   DONE                      one-cycle burst completion pulse
//   ADDR/CE/CSB/WEB/OEB/IDATA registered controller strobes
//   ODATA                     read byte from the controller
module memctrl_host_initiator
    import memctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [LEN_W-1:0]  REQ_LEN,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              DONE,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              CSB,
    output logic              WEB,
    output logic              OEB,
    output logic [DATA_W-1:0] IDATA,
    input  logic [DATA_W-1:0] ODATA
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] idata_reg, idata_next;
    logic              ce_reg, ce_next;
    logic              csb_reg, csb_next;
    logic              web_reg, web_next;
    logic              oeb_reg, oeb_next;
    logic              done_reg, done_next;
    logic              rd_empty;
    logic              rd_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            addr_reg      <= '0;
            idata_reg     <= '0;
            ce_reg        <= 1'b0;
            csb_reg       <= 1'b1;
            web_reg       <= 1'b1;
            oeb_reg       <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            remaining_reg <= remaining_next;
            addr_reg      <= addr_next;
            idata_reg     <= idata_next;
            ce_reg        <= ce_next;
            csb_reg       <= csb_next;
            web_reg       <= web_next;
            oeb_reg       <= oeb_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        remaining_next = remaining_reg;
        addr_next      = addr_reg;
        idata_next     = idata_reg;
        ce_next        = 1'b0;
        csb_next       = 1'b1;
        web_next       = 1'b1;
        oeb_next       = 1'b1;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (REQ_VALID) begin
                    cur_addr_next  = REQ_ADDR;
                    remaining_next = REQ_LEN;
                    state_next     = REQ_WRITE ? WRITE : READ;
                end
            end
            WRITE: begin
                if (WVALID) begin
                    ce_next        = 1'b1;
                    csb_next       = 1'b0;
                    web_next       = 1'b0;
                    addr_next      = cur_addr_reg;
                    idata_next     = WDATA;
                    cur_addr_next  = cur_addr_reg + ADDR_W'(1);
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                ce_next        = 1'b1;
                csb_next       = 1'b0;
                oeb_next       = 1'b0;
                addr_next      = cur_addr_reg;
                cur_addr_next  = cur_addr_reg + ADDR_W'(1);
                remaining_next = remaining_reg - LEN_W'(1);
                if (remaining_reg == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Empty is reached in the cycle of the last RVALID, so
                // REQ_READY rises the cycle after DONE.
                if (rd_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    memctrl_rd_tracker #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_tracker (
        .clk    (CLK),
        .rst    (RST),
        .issue  (ce_reg & ~oeb_reg),
        .odata  (ODATA),
        .rvalid (rd_valid),
        .rdata  (RDATA),
        .empty  (rd_empty)
    );

    assign REQ_READY = (state_reg == IDLE);
    assign WREADY    = (state_reg == WRITE);
    assign RVALID    = rd_valid;
    // Write completion is registered with the last beat; read completion
    // coincides with the final returned beat.
    assign DONE      = done_reg | ((state_reg == DRAIN) & rd_valid & rd_empty);
    assign ADDR      = addr_reg;
    assign CE        = ce_reg;
    assign CSB       = csb_reg;
    assign WEB       = web_reg;
    assign OEB       = oeb_reg;
    assign IDATA     = idata_reg;

endmodule

// File: doc/memctrl_host_initiator.md
Name: memctrl_host_initiator

Overview:
- Host-side initiator for the interleaved SRAM memory controller.
- Accepts burst requests on a valid/ready host interface and expands them into per-beat controller strobes: ADDR, CE, CSB, WEB, OEB, IDATA.
- Tracks read latency, captures the controller's muxed read byte (ODATA) and returns it to the host with RVALID.
- Sits between the system bus adapter and the controller's address-decode/bank-select stage, as the other end of that strobe interface.

Parameters:
- ADDR_W, 16, controller address width; [15:14] is bank, [13:10] is macro, [9:0] is word.
- DATA_W, 8, data byte width.
- LEN_W, 8, burst-length field width; a burst is REQ_LEN+1 beats.
- RD_LAT, 2, cycles from issuing a read beat on the memory outputs to ODATA being valid. Legal range is 1 to 7.

Ports:
- CLK  input  1  Single clock.
- RST  input  1  Asynchronous reset, active-high.
- REQ_VALID  input  1  Burst request valid.
- REQ_READY  output  1  Request accepted when both REQ_VALID and REQ_READY are high. Equal to (state==IDLE).
- REQ_WRITE  input  1  1 = write burst, 0 = read burst.
- REQ_ADDR  input  ADDR_W  Burst start address.
- REQ_LEN  input  LEN_W  Beats minus 1.
- WDATA  input  DATA_W  Write beat data.
- WVALID  input  1  Write beat valid.
- WREADY  output  1  Equal to (state==WRITE); a beat transfers when WVALID and WREADY are both high.
- RDATA  output  DATA_W  Read return data.
- RVALID  output  1  One-cycle pulse per returned beat. No backpressure: the host must accept every pulse.
- DONE  output  1  One-cycle pulse when a burst completes.
- ADDR  output  ADDR_W  Controller address, registered.
- CE  output  1  Controller access enable, registered; high during an active beat.
- CSB  output  1  Chip select, active-low, registered.
- WEB  output  1  Write enable, active-low, registered.
- OEB  output  1  Output enable, active-low, registered.
- IDATA  output  DATA_W  Write data to the controller, registered.
- ODATA  input  DATA_W  Read byte from the controller's macro select mux.

Behaviour:
- Reset (asynchronous, RST=1) forces:
  - ADDR=0, CE=0, CSB=1, WEB=1, OEB=1, IDATA=0.
  - RDATA=0, RVALID=0, DONE=0.
  - state=IDLE, beat counter=0, latency tracker cleared.
  - REQ_READY therefore reads 1 during reset.
- States:
  - IDLE: on REQ_VALID, latch REQ_ADDR into cur_addr and REQ_LEN into remaining. Go to WRITE if REQ_WRITE=1, otherwise READ.
  - WRITE: each cycle with WVALID=1 issues one beat on the next edge:
    - CSB=0, WEB=0, OEB=1, CE=1, ADDR=cur_addr, IDATA=WDATA.
    - Then cur_addr increments and remaining decrements.
    - A cycle with WVALID=0 issues an idle beat: CE=0, CSB=1, WEB=1, OEB=1; ADDR and IDATA hold.
    - When the last beat is issued (remaining==0 and WVALID=1), DONE pulses in the same cycle the last beat appears on the outputs, and state returns to IDLE.
  - READ: issues one beat every cycle with no gaps:
    - CSB=0, WEB=1, OEB=0, CE=1, ADDR=cur_addr.
    - After the last beat is issued, go to DRAIN.
  - DRAIN: memory outputs are idle (CE=0, CSB=1, OEB=1). Wait until the tracker is empty, then return to IDLE.
    - DONE pulses in the same cycle as the last RVALID.
- Read latency:
  - A read beat visible on the outputs in cycle t has ODATA valid in cycle t+RD_LAT.
  - ODATA is registered into RDATA; RVALID=1 in cycle t+RD_LAT+1.
  - Total latency from issue to RVALID is RD_LAT+1. Returns are in order, one per cycle, back to back.
- Address arithmetic:
  - cur_addr increments modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000 with no error.
  - Bank and macro fields are not treated specially; crossing a bank or macro boundary is just a carry.
- A single-beat burst (REQ_LEN=0) is legal.
- A maximum burst (REQ_LEN=255) is 256 beats.
- REQ_READY is low in WRITE, READ and DRAIN. A new request is held off until IDLE, so there is no overlap between bursts.
- RDATA holds its last value when RVALID=0.
- Reset mid-burst:
  - Outstanding reads are discarded and no RVALID or DONE follows.
  - The memory strobes deassert immediately, asynchronously.
- Write-then-read ordering is guaranteed because bursts are serialised. A read issued the cycle after a write completes must observe the written data.

Decomposition:
- memctrl_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN);
  - ADDR_W, DATA_W, LEN_W defaults;
  - the bank/macro/word field-position constants, shared with the controller decode.
- Sub-module memctrl_rd_tracker: an RD_LAT+1 deep valid shift register plus the ODATA capture. Outputs are RVALID, RDATA and empty.

Test Plan:
- Reset then idle → all outputs at reset values and REQ_READY=1. Assert RST mid-READ → CSB=1 and OEB=1 within the same cycle, and no RVALID afterwards.
- Write burst ADDR=16'h0000, LEN=3, WDATA 8'hA0 to 8'hA3 with WVALID low on the second cycle → four CSB=0/WEB=0 beats on ADDR 0 to 3 with one idle gap, and DONE on the fourth beat.
- Read back ADDR=16'h0000, LEN=3 with a memory model at RD_LAT=2 → RVALID in four consecutive cycles starting 3 cycles after the first issued beat, RDATA A0, A1, A2, A3, and DONE with the last RVALID.
- Wrap: read ADDR=16'hFFFE, LEN=3 → ADDR sequence FFFE, FFFF, 0000, 0001.
- Bank crossing: write ADDR=16'h3FFF, LEN=1 → beats on 3FFF (bank 0, macro 15) and 4000 (bank 1, macro 0), then read back matches.
- Request held during DRAIN: REQ_VALID asserted during the read of the previous scenario → REQ_READY=0 until the cycle after DONE, and the request is accepted the next cycle.
